// File: rtl/mac_accumulator.sv
// Signed, saturating dot-product accumulator fed by the pipelined Booth multiplier.
// A valid pipeline tracks in-flight products; each vector sum is presented on a valid/ready port.
module mac_accumulator #(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int COUNT_WIDTH = 8,
  parameter int MUL_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [COUNT_WIDTH-1:0]      len,
  input  logic signed [2*WIDTH-1:0]   mul2acc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_acc,
  output logic                        out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [COUNT_WIDTH-1:0]      CNT_ONE = COUNT_WIDTH'(1);

  state_t                       r_state;
  logic [COUNT_WIDTH-1:0]       r_len_q;
  logic [COUNT_WIDTH-1:0]       r_iss_cnt;
  logic [COUNT_WIDTH-1:0]       r_rcv_cnt;
  logic [MUL_LATENCY-1:0]       r_vpipe;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_ovf;
  logic                         r_in_ready;
  logic                         r_out_valid;

  logic                         w_issue;
  logic                         w_pv;
  logic [COUNT_WIDTH-1:0]       w_len_eff;
  logic [COUNT_WIDTH-1:0]       w_iss_next;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic                         w_sat;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;

  assign w_issue    = in_valid && r_in_ready;
  assign w_pv       = r_vpipe[MUL_LATENCY-1];
  assign w_len_eff  = (len == '0) ? CNT_ONE : len;
  assign w_iss_next = r_iss_cnt + CNT_ONE;

  // Both operands fit in ACC_WIDTH bits, so the ACC_WIDTH+1 sum is exact and a
  // mismatch of its top two bits means the result left the signed range.
  assign w_sum      = {r_acc[ACC_WIDTH-1], r_acc}
                    + {{(ACC_WIDTH+1-2*WIDTH){mul2acc[2*WIDTH-1]}}, mul2acc};
  assign w_sat      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
  assign w_acc_next = !w_sat          ? w_sum[ACC_WIDTH-1:0] :
                      w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;

  // NOTE: rst is synchronous and clears every state bit, including the valid
  // pipeline, so products already inside the multiplier are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= w_issue;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        r_vpipe[k] <= r_vpipe[k-1];
      end
    end
  end

  // NOTE: non-blocking assignments make every register read its pre-edge value,
  // so the order of statements inside the block does not change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len_q     <= '0;
      r_iss_cnt   <= '0;
      r_rcv_cnt   <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state    <= S_RUN;
            r_len_q    <= w_len_eff;
            r_iss_cnt  <= CNT_ONE;
            r_in_ready <= (CNT_ONE < w_len_eff);
          end
        end

        S_RUN: begin
          if (w_issue) begin
            r_iss_cnt  <= w_iss_next;
            r_in_ready <= (w_iss_next < r_len_q);
          end
          if (w_pv) begin
            r_acc     <= w_acc_next;
            r_ovf     <= r_ovf | w_sat;
            r_rcv_cnt <= r_rcv_cnt + CNT_ONE;
            if (r_rcv_cnt == r_len_q - CNT_ONE) begin
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_iss_cnt   <= '0;
            r_rcv_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;

endmodule
